// File: rtl/keccak_pkg.sv
// Shared Keccak constants and chi-stage types.
// Used by chi_step and chi_row.
package keccak_pkg;

    localparam int unsigned LANE_W   = 64;
    localparam int unsigned ROW_LN   = 5;
    localparam int unsigned N_LANES  = 25;
    localparam int unsigned ROUND_W  = 5;
    localparam int unsigned N_ROUNDS = 24;
    localparam int unsigned CNT_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } chi_state_t;

    // Column successor within a row, mod 5, by compare rather than slicing.
    function automatic logic [CNT_W-1:0] mod5_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_W'(ROW_LN - 1)) ? '0 : CNT_W'(v + CNT_W'(1));
    endfunction

endpackage

// File: rtl/chi_row.sv
// Combinational Keccak chi over one 5-lane row:
// A'[x] = A[x] ^ (~A[x+1] & A[x+2]), indices mod 5.
module chi_row #(
    parameter int unsigned LANE_W = keccak_pkg::LANE_W
) (
    input  logic [LANE_W-1:0] lanes_i [keccak_pkg::ROW_LN],
    output logic [LANE_W-1:0] chi_c   [keccak_pkg::ROW_LN]
);
    import keccak_pkg::*;

    logic [CNT_W-1:0] i1;
    logic [CNT_W-1:0] i2;

    always_comb begin
        i1 = '0;
        i2 = '0;
        for (int i = 0; i < int'(ROW_LN); i++) begin
            i1       = mod5_inc(CNT_W'(i));
            i2       = mod5_inc(i1);
            chi_c[i] = lanes_i[i] ^ (~lanes_i[i1] & lanes_i[i2]);
        end
    end

endmodule

// File: rtl/chi_step.sv
// Keccak-f[1600] chi stage: buffers one row of lanes, emits its chi result lane by lane.
// Optional CHI_BYPASS_EN adds a bypass input that passes lanes through unchanged.
module chi_step #(
    parameter int unsigned LANE_W  = keccak_pkg::LANE_W,
    parameter int unsigned ROUND_W = keccak_pkg::ROUND_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ROUND_W-1:0] iteration,
`ifdef CHI_BYPASS_EN
    input  logic               bypass,
`endif
    input  logic               in_valid,
    input  logic [LANE_W-1:0]  in_lane,
    output logic               in_ready,
    output logic               out_valid,
    output logic [LANE_W-1:0]  out_lane,
    input  logic               out_ready,
    output logic [ROUND_W-1:0] iter_out,
    output logic               busy,
    output logic               finish
);
    import keccak_pkg::*;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROW_LN - 1);

    chi_state_t          state_q, state_d;
    logic [CNT_W-1:0]    x_q, x_d;
    logic [CNT_W-1:0]    row_q, row_d;
    logic [ROUND_W-1:0]  iter_q, iter_d;
    logic [LANE_W-1:0]   rowbuf_q [ROW_LN];
    logic [LANE_W-1:0]   rowbuf_d [ROW_LN];
    logic [LANE_W-1:0]   chi_c    [ROW_LN];
    logic [LANE_W-1:0]   emit_lane_c;
    logic [LANE_W-1:0]   out_lane_q, out_lane_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                finish_q, finish_d;
`ifdef CHI_BYPASS_EN
    logic                bypass_q, bypass_d;
`endif

    // Next state, counters and row buffer.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        row_d    = row_q;
        iter_d   = iter_q;
        rowbuf_d = rowbuf_q;
`ifdef CHI_BYPASS_EN
        bypass_d = bypass_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    iter_d  = iteration;
`ifdef CHI_BYPASS_EN
                    bypass_d = bypass;
`endif
                    row_d   = '0;
                    x_d     = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    rowbuf_d[x_q] = in_lane;
                    if (x_q == LAST_IDX) begin
                        x_d     = '0;
                        state_d = EMIT;
                    end else begin
                        x_d = CNT_W'(x_q + CNT_W'(1));
                    end
                end
            end
            EMIT: begin
                if (out_valid_q && out_ready) begin
                    if (x_q == LAST_IDX) begin
                        x_d = '0;
                        if (row_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            row_d   = CNT_W'(row_q + CNT_W'(1));
                            state_d = LOAD;
                        end
                    end else begin
                        x_d = CNT_W'(x_q + CNT_W'(1));
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    chi_row #(.LANE_W(LANE_W)) u_chi_row (
        .lanes_i (rowbuf_d),
        .chi_c   (chi_c)
    );

`ifdef CHI_BYPASS_EN
    assign emit_lane_c = bypass_q ? rowbuf_d[x_d] : chi_c[x_d];
`else
    assign emit_lane_c = chi_c[x_d];
`endif

    // Registered outputs are decoded from the upcoming state so they align with it.
    always_comb begin
        in_ready_d  = (state_d == LOAD);
        out_valid_d = (state_d == EMIT);
        busy_d      = (state_d != IDLE);
        finish_d    = (state_d == DONE);
        out_lane_d  = out_lane_q;
        if (state_d == EMIT) begin
            out_lane_d = emit_lane_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            row_q       <= '0;
            iter_q      <= '0;
            out_lane_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
`ifdef CHI_BYPASS_EN
            bypass_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            row_q       <= row_d;
            iter_q      <= iter_d;
            out_lane_q  <= out_lane_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            finish_q    <= finish_d;
`ifdef CHI_BYPASS_EN
            bypass_q    <= bypass_d;
`endif
        end
    end

    // Row buffer content is don't-care after reset.
    always_ff @(posedge clk) begin
        rowbuf_q <= rowbuf_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_lane  = out_lane_q;
    assign iter_out  = iter_q;
    assign busy      = busy_q;
    assign finish    = finish_q;

endmodule

// File: tb/tb_chi_step.sv
// Self-checking bench for chi_step against a whole-state chi reference model.
// Build with CHI_BYPASS_EN defined to also exercise the bypass path.
module tb_chi_step;

    localparam int unsigned LW = 64;
    localparam int unsigned RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [RW-1:0] iteration;
    logic          bypass;
    logic          in_valid;
    logic [LW-1:0] in_lane;
    logic          in_ready;
    logic          out_valid;
    logic [LW-1:0] out_lane;
    logic          out_ready;
    logic [RW-1:0] iter_out;
    logic          busy;
    logic          finish;

    int checks   = 0;
    int failures = 0;

    logic [LW-1:0] st_in  [25];
    logic [LW-1:0] st_exp [25];

    chi_step dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .iteration (iteration),
`ifdef CHI_BYPASS_EN
        .bypass    (bypass),
`endif
        .in_valid  (in_valid),
        .in_lane   (in_lane),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_lane  (out_lane),
        .out_ready (out_ready),
        .iter_out  (iter_out),
        .busy      (busy),
        .finish    (finish)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] rand_lane();
        return {$urandom(), $urandom()};
    endfunction

    // Reference: chi over the whole 5x5 state using plain modular arithmetic.
    task automatic build_expected(input bit byp);
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                if (byp)
                    st_exp[5*y+x] = st_in[5*y+x];
                else
                    st_exp[5*y+x] = st_in[5*y+x] ^
                        (~st_in[5*y+((x+1)%5)] & st_in[5*y+((x+2)%5)]);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            finish !== 1'b0 || out_lane !== '0 || iter_out !== '0) begin
            failures++;
            $display("FAIL %s: in_ready=%b out_valid=%b busy=%b finish=%b out_lane=%h iter_out=%0d, required all zero",
                     tag, in_ready, out_valid, busy, finish, out_lane, iter_out);
        end
    endtask

    // Drives one full state through the DUT and checks every output lane and handshake rule.
    task automatic run_state(input logic [RW-1:0] it, input bit rnd_in, input bit rnd_out,
                             input int stall_at, input int start_at, input bit byp,
                             input string tag);
        int in_idx, out_idx, cyc, stall_left, n_fin;
        bit last_in_row, held_v, fin;
        logic [LW-1:0] held_lane;
        build_expected(byp);
        @(negedge clk);
        start = 1'b1; iteration = it; bypass = byp;
        @(negedge clk);
        start = 1'b0; iteration = ~it; bypass = ~byp;
        in_idx = 0; out_idx = 0; cyc = 0; stall_left = 3; n_fin = 0;
        last_in_row = 0; held_v = 0; fin = 0; held_lane = '0;
        while (!fin && cyc < 2000) begin
            if (last_in_row) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL %s latency: out_valid=%b one cycle after row end, required 1", tag, out_valid);
                end
            end
            if (held_v) begin
                checks++;
                if (out_valid !== 1'b1 || out_lane !== held_lane) begin
                    failures++;
                    $display("FAIL %s hold: out_valid=%b out_lane=%h, required 1 and %h", tag, out_valid, out_lane, held_lane);
                end
            end
            if (in_ready === 1'b1 && out_valid === 1'b1) begin
                checks++;
                failures++;
                $display("FAIL %s exclusive: in_ready and out_valid both 1, required not both", tag);
            end
            if (busy !== 1'b1 || iter_out !== it) begin
                checks++;
                failures++;
                $display("FAIL %s active: busy=%b iter_out=%0d, required 1 and %0d", tag, busy, iter_out, it);
            end
            in_valid = (in_idx < 25) && (!rnd_in || $urandom_range(0, 3) != 0);
            in_lane  = (in_idx < 25) ? st_in[in_idx] : rand_lane();
            if (out_idx == stall_at && out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = rnd_out ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            start = (start_at >= 0 && out_idx == start_at && out_valid);
            iteration = RW'($urandom());
            last_in_row = 0;
            held_v = 0;
            if (in_valid && in_ready) begin
                last_in_row = (in_idx % 5 == 4);
                in_idx++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_idx >= 25) begin
                    failures++;
                    $display("FAIL %s extra lane: lane %0d emitted, required 25 only", tag, out_idx);
                end else if (out_lane !== st_exp[out_idx]) begin
                    failures++;
                    $display("FAIL %s lane %0d: got %h, required %h", tag, out_idx, out_lane, st_exp[out_idx]);
                end
                out_idx++;
            end else if (out_valid) begin
                held_v = 1;
                held_lane = out_lane;
            end
            if (finish) begin
                fin = 1;
                n_fin++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        checks++;
        if (!fin || out_idx != 25 || in_idx != 25) begin
            failures++;
            $display("FAIL %s completion: finish_seen=%0d lanes_in=%0d lanes_out=%0d, required 1/25/25", tag, fin, in_idx, out_idx);
        end
        checks++;
        if (finish !== 1'b0 || busy !== 1'b0 || iter_out !== it) begin
            failures++;
            $display("FAIL %s after_finish: finish=%b busy=%b iter_out=%0d, required 0 0 %0d", tag, finish, busy, iter_out, it);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; iteration = '0; bypass = 1'b0;
        in_valid = 1'b0; in_lane = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("reset");
        @(negedge clk);
        check_idle_outputs("reset_hold");
    endtask

    task automatic test_zero_state();
        for (int i = 0; i < 25; i++) st_in[i] = '0;
        run_state(RW'(3), 1'b0, 1'b0, -1, -1, 1'b0, "zero_state");
    endtask

    task automatic test_row0_pattern();
        for (int i = 0; i < 25; i++) st_in[i] = '0;
        st_in[0] = '1;
        run_state(RW'(7), 1'b0, 1'b0, -1, -1, 1'b0, "row0_pattern");
        checks++;
        if (st_exp[0] !== {LW{1'b1}} || st_exp[3] !== {LW{1'b1}} || st_exp[1] !== '0) begin
            failures++;
            $display("FAIL row0_model: exp0=%h exp1=%h exp3=%h, required ones/zero/ones", st_exp[0], st_exp[1], st_exp[3]);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 25; i++) st_in[i] = rand_lane();
        run_state(RW'(11), 1'b0, 1'b0, 7, -1, 1'b0, "backpressure");
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < 25; i++) st_in[i] = rand_lane();
        run_state(RW'(21), 1'b0, 1'b0, -1, 12, 1'b0, "start_ignored");
    endtask

    task automatic test_reset_mid();
        int in_idx, cyc;
        bit saw_fin;
        for (int i = 0; i < 25; i++) st_in[i] = rand_lane();
        @(negedge clk);
        start = 1'b1; iteration = RW'(9);
        @(negedge clk);
        start = 1'b0;
        in_idx = 0; cyc = 0;
        out_ready = 1'b1;
        while (in_idx < 17 && cyc < 500) begin
            in_valid = (in_idx < 25);
            in_lane = st_in[in_idx];
            if (in_valid && in_ready) in_idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (in_idx != 17 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid reach: lanes_in=%0d in_ready=%b, required 17 and 1", in_idx, in_ready);
        end
        rst = 1'b1; start = 1'b1; iteration = RW'(30);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check_idle_outputs("reset_mid");
        saw_fin = 0;
        repeat (4) begin
            @(negedge clk);
            if (finish !== 1'b0 || busy !== 1'b0) saw_fin = 1;
        end
        checks++;
        if (saw_fin) begin
            failures++;
            $display("FAIL reset_mid quiet: finish/busy asserted after abort, required 0");
        end
        for (int i = 0; i < 25; i++) st_in[i] = rand_lane();
        run_state(RW'(5), 1'b1, 1'b1, -1, -1, 1'b0, "after_reset_mid");
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 25; i++) st_in[i] = rand_lane();
            run_state(RW'($urandom_range(0, 23)), 1'b1, 1'b1, -1, -1, 1'b0, "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 25; i++) st_in[i] = rand_lane();
            run_state(RW'(n + 1), 1'b0, 1'b0, -1, -1, 1'b0, "back_to_back");
        end
    endtask

    task automatic test_bypass();
`ifdef CHI_BYPASS_EN
        for (int i = 0; i < 25; i++) st_in[i] = LW'(i);
        run_state(RW'(2), 1'b1, 1'b1, -1, -1, 1'b1, "bypass");
        for (int i = 0; i < 25; i++) st_in[i] = rand_lane();
        run_state(RW'(4), 1'b0, 1'b1, -1, -1, 1'b0, "bypass_off");
`endif
    endtask

    initial begin
        test_reset();
        test_zero_state();
        test_row0_pattern();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_random();
        test_back_to_back();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
